// File: rtl/boreal_mmio_pkg.sv
// Shared definitions for the Boreal MMIO arbiter: default widths, FSM state
// encodings, requester IDs and the default host write-protection base.
package boreal_mmio_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;
  localparam logic [9:0]  WPROT_BASE_DEF = 10'h380;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } mmio_state_t;

  typedef enum logic {
    REQ_HOST = 1'b0,
    REQ_CORE = 1'b1
  } req_id_t;

endpackage

// File: rtl/boreal_rr_arb2.sv
// Two-input round-robin arbiter. A lone requester always wins; on a tie the
// requester that was not granted last wins. The last-grant pointer advances
// only when the caller signals that the grant was accepted.
module boreal_rr_arb2
  import boreal_mmio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant,
  output req_id_t    grant_id
);

  req_id_t last;

  // Grant selection: core wins if it is alone or if host was granted last
  always_comb begin
    grant_id = REQ_HOST;
    if (req[1] && (!req[0] || last == REQ_HOST)) grant_id = REQ_CORE;
    grant    = '0;
    grant[0] = req[0] && (grant_id == REQ_HOST);
    grant[1] = req[1] && (grant_id == REQ_CORE);
  end

  // Last-grant pointer; starts at core so host wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                last <= REQ_CORE;
    else if (update && |req)   last <= grant_id;
  end

endmodule

// File: rtl/boreal_mmio_arbiter.sv
// Boreal MMIO arbiter/sequencer: shares the single-port MMIO bus between the
// host frame decoder and the core sequencer, one transaction at a time.
// Optional feature macro BOREAL_MMIO_WPROT_EN: host writes at or above
// WPROT_BASE are suppressed and answered with h_rsp_err.
module boreal_mmio_arbiter
  import boreal_mmio_pkg::*;
#(
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter int unsigned       RD_LAT     = 1,
  parameter logic [ADDR_W-1:0] WPROT_BASE = ADDR_W'(WPROT_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              h_req_valid,
  output logic              h_req_ready,
  input  logic              h_req_we,
  input  logic [ADDR_W-1:0] h_req_addr,
  input  logic [DATA_W-1:0] h_req_wdata,
  output logic              h_rsp_valid,
  output logic [DATA_W-1:0] h_rsp_rdata,
  output logic              h_rsp_err,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

`ifdef BOREAL_MMIO_WPROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  localparam logic [2:0] LAT_LAST = 3'(RD_LAT - 1);

  mmio_state_t       state, state_nxt;
  req_id_t           grant_id, owner_q;
  logic [1:0]        grant;
  logic              idle, accept, sel_core, sel_we, prot_hit;
  logic [ADDR_W-1:0] sel_addr, addr_q;
  logic [DATA_W-1:0] sel_wdata, wdata_q, rdata_q;
  logic              we_q, err_q;
  logic [2:0]        cnt_q;

  assign idle   = (state == ST_IDLE);
  assign accept = idle && (h_req_valid || c_req_valid);

  boreal_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      ({c_req_valid, h_req_valid}),
    .update   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign h_req_ready = idle && grant[0];
  assign c_req_ready = idle && grant[1];

  // Winner payload mux and host write-protection decision
  always_comb begin
    sel_core  = (grant_id == REQ_CORE);
    sel_we    = sel_core ? c_req_we    : h_req_we;
    sel_addr  = sel_core ? c_req_addr  : h_req_addr;
    sel_wdata = sel_core ? c_req_wdata : h_req_wdata;
    prot_hit  = PROT_EN && !sel_core && sel_we && (sel_addr >= WPROT_BASE);
  end

  // State register and WAIT-phase latency counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_nxt;
      cnt_q <= (state == ST_WAIT) ? cnt_q + 3'd1 : '0;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = we_q ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (cnt_q == LAT_LAST) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Latch the accepted request; capture read data on the last WAIT cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= REQ_HOST;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      owner_q <= grant_id;
      we_q    <= sel_we;
      err_q   <= prot_hit;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      rdata_q <= '0;
    end else if (state == ST_WAIT && cnt_q == LAT_LAST) begin
      rdata_q <= mem_dout;
    end
  end

  assign mem_we   = (state == ST_ISSUE) && we_q && !err_q;
  assign mem_addr = addr_q;
  assign mem_din  = wdata_q;

  assign h_rsp_valid = (state == ST_RESP) && (owner_q == REQ_HOST);
  assign c_rsp_valid = (state == ST_RESP) && (owner_q == REQ_CORE);
  assign h_rsp_rdata = h_rsp_valid ? rdata_q : '0;
  assign c_rsp_rdata = c_rsp_valid ? rdata_q : '0;
  assign h_rsp_err   = h_rsp_valid && err_q;

endmodule

// File: tb/tb_boreal_mmio_arbiter.sv
// Self-checking bench for boreal_mmio_arbiter: directed scenarios followed by
// randomized traffic, checked against a transaction-level reference model.
module tb_boreal_mmio_arbiter;

  localparam int unsigned RD_LAT = 3;
  localparam logic [9:0]  PBASE  = 10'h380;
`ifdef BOREAL_MMIO_WPROT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        h_req_valid, h_req_ready, h_req_we, h_rsp_valid, h_rsp_err;
  logic [9:0]  h_req_addr;
  logic [31:0] h_req_wdata, h_rsp_rdata;
  logic        c_req_valid, c_req_ready, c_req_we, c_rsp_valid;
  logic [9:0]  c_req_addr;
  logic [31:0] c_req_wdata, c_rsp_rdata;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;

  always #5 clk = ~clk;

  boreal_mmio_arbiter #(.RD_LAT(RD_LAT), .WPROT_BASE(PBASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .h_req_valid(h_req_valid), .h_req_ready(h_req_ready), .h_req_we(h_req_we),
    .h_req_addr(h_req_addr), .h_req_wdata(h_req_wdata), .h_rsp_valid(h_rsp_valid),
    .h_rsp_rdata(h_rsp_rdata), .h_rsp_err(h_rsp_err),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_rsp_valid(c_rsp_valid),
    .c_rsp_rdata(c_rsp_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Register file model with RD_LAT cycles of read latency
  logic [31:0] mem_arr [1024] = '{default: 32'h0};
  logic [31:0] pipe [RD_LAT]  = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_din;
    pipe[0] <= mem_arr[mem_addr];
    for (int i = 1; i < int'(RD_LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign mem_dout = pipe[RD_LAT-1];

  // Reference model state: expected register contents and round-robin pointer
  logic [31:0] ref_mem [1024] = '{default: 32'h0};
  bit          last_core = 1'b1;
  int unsigned passes = 0, checks = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_h(input logic we, input logic [9:0] a, input logic [31:0] d);
    h_req_valid = 1'b1; h_req_we = we; h_req_addr = a; h_req_wdata = d;
  endtask

  task automatic drive_c(input logic we, input logic [9:0] a, input logic [31:0] d);
    c_req_valid = 1'b1; c_req_we = we; c_req_addr = a; c_req_wdata = d;
  endtask

  function automatic logic [9:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 10'h380;
      1:       return 10'h3FF;
      2:       return 10'h37F;
      default: return 10'($urandom_range(0, 15));
    endcase
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_h_ready"}, 32'(h_req_ready), 32'(0));
    check({tag, "_c_ready"}, 32'(c_req_ready), 32'(0));
    check({tag, "_h_rsp_valid"}, 32'(h_rsp_valid), 32'(0));
    check({tag, "_c_rsp_valid"}, 32'(c_rsp_valid), 32'(0));
    check({tag, "_h_rsp_err"}, 32'(h_rsp_err), 32'(0));
    check({tag, "_h_rsp_rdata"}, h_rsp_rdata, 32'h0);
    check({tag, "_c_rsp_rdata"}, c_rsp_rdata, 32'h0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'(0));
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'(0));
    check({tag, "_mem_din"}, mem_din, 32'h0);
  endtask

  // One transaction from the current IDLE cycle (called at a negedge with the
  // requests already driven); w returns 0 = host, 1 = core, -1 = nothing pending.
  task automatic step(input bit mid_core, output int w);
    logic hv, cv, we, blocked;
    logic [9:0]  a;
    logic [31:0] d, exp_rd;
    int resp_k;
    hv = h_req_valid; cv = c_req_valid; w = -1;
    if (!hv && !cv) return;
    w = (hv && cv) ? (last_core ? 0 : 1) : (hv ? 0 : 1);
    #1;
    check("h_ready_idle", 32'(h_req_ready), 32'(w == 0));
    check("c_ready_idle", 32'(c_req_ready), 32'(w == 1));
    we = (w == 1) ? c_req_we : h_req_we;
    a  = (w == 1) ? c_req_addr : h_req_addr;
    d  = (w == 1) ? c_req_wdata : h_req_wdata;
    blocked = PROT && (w == 0) && we && (a >= PBASE);
    exp_rd  = we ? 32'h0 : ref_mem[a];
    if (we && !blocked) ref_mem[a] = d;
    last_core = (w == 1);
    @(posedge clk); #1;
    if (w == 0) begin
      h_req_valid = 1'b0; h_req_we = 1'($urandom); h_req_addr = 10'($urandom); h_req_wdata = $urandom;
    end else begin
      c_req_valid = 1'b0; c_req_we = 1'($urandom); c_req_addr = 10'($urandom); c_req_wdata = $urandom;
    end
    resp_k = we ? 2 : 2 + int'(RD_LAT);
    for (int k = 1; k <= resp_k; k++) begin
      @(negedge clk);
      if (mid_core && k == 2 && !c_req_valid) drive_c(1'($urandom), rand_addr(), $urandom);
      #1;
      check("h_ready_busy", 32'(h_req_ready), 32'(0));
      check("c_ready_busy", 32'(c_req_ready), 32'(0));
      check("mem_we", 32'(mem_we), 32'(k == 1 && we && !blocked));
      if (k < resp_k) check("mem_addr", 32'(mem_addr), 32'(a));
      if (k == 1 && we) check("mem_din", mem_din, d);
      check("h_rsp_valid", 32'(h_rsp_valid), 32'(k == resp_k && w == 0));
      check("c_rsp_valid", 32'(c_rsp_valid), 32'(k == resp_k && w == 1));
      check("h_rsp_rdata", h_rsp_rdata, (k == resp_k && w == 0) ? exp_rd : 32'h0);
      check("c_rsp_rdata", c_rsp_rdata, (k == resp_k && w == 1) ? exp_rd : 32'h0);
      check("h_rsp_err", 32'(h_rsp_err), 32'(k == resp_k && w == 0 && blocked));
    end
  endtask

  initial begin
    int w;
    h_req_valid = 1'b0; h_req_we = 1'b0; h_req_addr = '0; h_req_wdata = '0;
    c_req_valid = 1'b0; c_req_we = 1'b0; c_req_addr = '0; c_req_wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1 check_reset("rst");
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1 check_reset("post_rst");

    // Host write, then core read of the same word
    @(negedge clk); drive_h(1'b1, 10'h010, 32'hDEADBEEF); step(1'b0, w);
    check("grant_first_write", 32'(w), 32'(0));
    @(negedge clk); drive_c(1'b0, 10'h010, 32'h0); step(1'b0, w);
    check("grant_core_read", 32'(w), 32'(1));

    // Contention: both ports valid continuously
    @(negedge clk);
    drive_h(1'b1, 10'h001, $urandom); drive_c(1'b1, 10'h002, $urandom);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, w);
      check("rr_order", 32'(w), 32'(i % 2));
      @(negedge clk);
      if (w == 0) drive_h(1'($urandom), 10'($urandom_range(0, 15)), $urandom);
      else        drive_c(1'($urandom), 10'($urandom_range(0, 15)), $urandom);
    end
    step(1'b0, w);
    @(negedge clk); step(1'b0, w);

    // Busy hold-off: core raises valid during a host read's WAIT
    @(negedge clk); drive_h(1'b0, 10'h010, 32'h0); step(1'b1, w);
    check("holdoff_first", 32'(w), 32'(0));
    @(negedge clk); step(1'b0, w);
    check("holdoff_core", 32'(w), 32'(1));

    // Protected range: host and core writes to the top word, plus boundary
    @(negedge clk); drive_h(1'b1, 10'h3FF, 32'h12345678); step(1'b0, w);
    @(negedge clk); drive_h(1'b0, 10'h3FF, 32'h0); step(1'b0, w);
    @(negedge clk); drive_c(1'b1, 10'h3FF, 32'hCAFEF00D); step(1'b0, w);
    @(negedge clk); drive_h(1'b0, 10'h3FF, 32'h0); step(1'b0, w);
    @(negedge clk); drive_h(1'b1, 10'h37F, 32'h0BADC0DE); step(1'b0, w);
    @(negedge clk); drive_c(1'b0, 10'h37F, 32'h0); step(1'b0, w);

    // Randomized traffic
    for (int it = 0; it < 80; it++) begin
      @(negedge clk);
      if (!h_req_valid && $urandom_range(0, 2) != 0) drive_h(1'($urandom), rand_addr(), $urandom);
      if (!c_req_valid && $urandom_range(0, 2) != 0) drive_c(1'($urandom), rand_addr(), $urandom);
      step($urandom_range(0, 3) == 0, w);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); step(1'b0, w);
    end

    // Reset during ISSUE of a write: strobe drops at once, nothing written
    @(negedge clk); drive_h(1'b1, 10'h020, 32'hA5A55A5A);
    #1 check("mw_ready", 32'(h_req_ready), 32'(1));
    @(posedge clk); #1 h_req_valid = 1'b0;
    @(negedge clk); #1 check("mw_we_issue", 32'(mem_we), 32'(1));
    rst_n = 1'b0;
    #1 check_reset("mw_rst");
    @(negedge clk); rst_n = 1'b1; last_core = 1'b1;
    @(negedge clk); drive_h(1'b0, 10'h020, 32'h0); step(1'b0, w);

    // Reset during WAIT of a read: response dropped, host wins next tie
    @(negedge clk); drive_h(1'b0, 10'h010, 32'h0);
    #1 check("mr_ready", 32'(h_req_ready), 32'(1));
    @(posedge clk); #1 h_req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset("mr_rst");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("mr_h_rsp", 32'(h_rsp_valid), 32'(0));
      check("mr_c_rsp", 32'(c_rsp_valid), 32'(0));
    end
    rst_n = 1'b1; last_core = 1'b1;
    @(negedge clk); #1 check_reset("mr_post");
    drive_h(1'b1, 10'h011, $urandom); drive_c(1'b1, 10'h012, $urandom);
    step(1'b0, w);
    check("post_rst_tie", 32'(w), 32'(0));
    @(negedge clk); step(1'b0, w);
    check("post_rst_core", 32'(w), 32'(1));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/boreal_mmio_arbiter.md
# boreal_mmio_arbiter

Two-requester arbiter and sequencer for the Boreal Neuro-Core MMIO register space (10-bit word address, 32-bit data). It shares the single-port MMIO bus between the UART host frame decoder (host port) and the on-chip core sequencer (core port). It serialises one transaction at a time, times read latency, and returns a per-requester response. It sits between both requesters and the register file/BRAM.

## Interface
- ADDR_W, 10, MMIO word-address width
- DATA_W, 32, MMIO data width
- RD_LAT, 1, register-file read latency in cycles; legal 1..4
- WPROT_BASE, 10'h380, lowest host-protected address (used only with the macro)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- h_req_valid / h_req_ready  in / out  1  host request handshake
- h_req_we  in  1  1 = write, 0 = read
- h_req_addr  in  ADDR_W  host address
- h_req_wdata  in  DATA_W  host write data
- h_rsp_valid  out  1  one-cycle host response pulse
- h_rsp_rdata  out  DATA_W  read data; 0 for writes
- h_rsp_err  out  1  protected-write error, qualified by h_rsp_valid
- c_req_valid, c_req_ready, c_req_we, c_req_addr, c_req_wdata, c_rsp_valid, c_rsp_rdata  core-port equivalents, same widths
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  MMIO address
- mem_din  out  DATA_W  write data
- mem_dout  in  DATA_W  read data

## Operation
- FSM states:
  - IDLE: arbitrate. On handshake go to ISSUE.
  - ISSUE: drive mem_*. Go to RESP on a write, WAIT on a read.
  - WAIT: count RD_LAT cycles, then go to RESP.
  - RESP: pulse the response, then return to IDLE.
- Ready is combinational. It is high only in IDLE and only for the arbitration winner. A transfer occurs on valid && ready.
- Requester rules: hold valid, we, addr and wdata stable until ready. Valid must not drop before ready.
- Arbitration is 2-way round-robin.
  - A last-grant pointer updates on each accepted request.
  - If only one port is valid, that port wins.
  - If both are valid, the port not granted last wins.
  - After reset the pointer equals core, so host wins the first tie.
- Accepted addr, we, wdata and requester ID are latched on the handshake. mem_addr and mem_din are held from ISSUE through WAIT.
- mem_we is high only during ISSUE of a write.
- Read capture: mem_dout is registered into the response data on the last WAIT cycle.
- Response: only the owning port's rsp_valid pulses in RESP. The other port's rsp outputs stay 0.
- No address checking: every ADDR_W value is legal.

## Timing
- Reset values: all ready/rsp_valid/rsp_err = 0; rsp_rdata = 0; mem_we = 0; mem_addr = 0; mem_din = 0; FSM = IDLE; pointer = core.
- Write accepted at cycle T:
  - mem_we = 1 at T+1.
  - rsp_valid at T+2.
  - Next accept possible at T+3.
- Read accepted at cycle T:
  - mem_addr valid from T+1.
  - Capture at T+1+RD_LAT.
  - rsp_valid at T+2+RD_LAT.
  - Next accept at T+3+RD_LAT.
- A request arriving in a non-IDLE state sees ready = 0 and waits. No queuing.
- Reset asserted mid-transaction: immediate return to reset values. The in-flight response is dropped and mem_we deasserts asynchronously. Requesters must reissue.

## Configuration
- BOREAL_MMIO_WPROT_EN defined:
  - A host write with addr >= WPROT_BASE still runs ISSUE timing, but mem_we stays 0.
  - The response carries h_rsp_err = 1.
  - Core writes and all reads are never blocked.
- Undefined: no protection, and h_rsp_err is tied to 0.

## Structure
- Shared package boreal_mmio_pkg holds:
  - ADDR_W/DATA_W defaults
  - FSM state encodings (IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3)
  - requester IDs (REQ_HOST = 0, REQ_CORE = 1)
  - the default WPROT_BASE
- One sub-module, boreal_rr_arb2: 2-input round-robin grant with a last-grant pointer and an update enable.

## Test plan
- Reset check: hold rst_n = 0 → every output at its reset value. Release, then host writes 0xDEADBEEF to 0x010 → mem_we pulse at T+1 with mem_addr 0x010; h_rsp_valid at T+2 with rdata 0.
- Read latency: RD_LAT = 3, core reads 0x010 with the model returning the stored value → c_rsp_valid exactly at T+5, c_rsp_rdata = 0xDEADBEEF, h_rsp_valid stays 0.
- Contention: both ports valid continuously for 4 transactions → grants H, C, H, C, with no transaction overlap.
- Busy hold-off: core raises valid during a host read's WAIT → c_req_ready stays 0 until IDLE, then accepted with stable payload.
- With BOREAL_MMIO_WPROT_EN:
  - Host writes 0x3FF → mem_we never asserts, h_rsp_err = 1.
  - Core write to 0x3FF → mem_we asserts, no error.
- Mid-read reset: assert rst_n = 0 in WAIT → no rsp_valid. After release, FSM in IDLE and host wins the next tie.
